// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I load/store requests into word-aligned data memory
// accesses, with sub-word extraction on loads and read-modify-write on sub-word stores.
module load_store_unit #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    localparam logic [2:0] F3W = 3'b010;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] sdata_q, sdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        req_illegal;
    logic        req_misal;
    logic        req_oor;
    logic        req_bad;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    // Classify the incoming request; any of the three faults yields an error response.
    always_comb begin
        req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        req_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_oor     = req_addr >= 32'(MEM_SIZE);
        req_bad     = req_illegal || req_misal || req_oor;
    end

    // Pick the addressed lane out of the memory word and extend it to 32 bits.
    always_comb begin
        ld_byte = rdata[7:0];
        case (lane_q)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = lane_q[1] ? rdata[31:16] : rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
            default: ld_ext = rdata;
        endcase
    end

    // Overlay the store data onto the word read back from memory.
    always_comb begin
        merged = rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (lane_q)
                2'd0:    merged[7:0]   = sdata_q[7:0];
                2'd1:    merged[15:8]  = sdata_q[7:0];
                2'd2:    merged[23:16] = sdata_q[7:0];
                default: merged[31:24] = sdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = sdata_q;
        end else begin
            merged[15:0] = sdata_q;
        end
    end

    // Next-state logic: request acceptance, read, write and response sequencing.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        sdata_d      = sdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    lane_d   = req_addr[1:0];
                    sdata_d  = req_wdata[15:0];
                    if (req_bad) begin
                        // Faulting requests never touch memory, so addr stays put.
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        state_d      = StResp;
                    end else begin
                        addr_d = {req_addr[31:2], 2'b00};
                        if (req_store && (req_funct3 == F3W)) begin
                            wdata_d = req_wdata;
                            state_d = StWr;
                        end else begin
                            state_d = StRd;
                        end
                    end
                end
            end
            StRd: begin
                if (store_q) begin
                    wdata_d = merged;
                    state_d = StWr;
                end else begin
                    resp_rdata_d = ld_ext;
                    resp_err_d   = 1'b0;
                    state_d      = StResp;
                end
            end
            StWr: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            sdata_q      <= 16'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            sdata_q      <= sdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Strobes decode straight from state so reset drops them immediately.
    always_comb begin
        req_ready  = (state_q == StIdle);
        we         = (state_q == StWr);
        resp_valid = (state_q == StResp);
        addr       = addr_q;
        wdata      = wdata_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic [31:0] mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_data = 32'h0;
    int          we_total = 0;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.MEM_SIZE(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    assign rdata = mem[addr[9:2]];

    always @(posedge clk) begin
        if (we) mem[addr[9:2]] <= wdata;
        else if (pre_en) mem[pre_idx] <= pre_data;
    end

    always @(posedge clk) begin
        if (we) we_total <= we_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Issue one request from IDLE and follow it to its response (cycle 1 = acceptance).
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_nwe, output logic [31:0] wa, output logic [31:0] wdv,
                           output int we_cyc);
        int lat;
        int nwe;
        logic [31:0] rd;
        logic er;
        lat = 0; nwe = 0; rd = 32'hx; er = 1'bx; wa = 32'h0; wdv = 32'h0; we_cyc = 0;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 2; c <= 10 && lat == 0; c++) begin
            if (we) begin
                nwe++;
                wa  = addr;
                wdv = wdata;
                if (we_cyc == 0) we_cyc = c;
            end
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " rdata"}, rd, exp_rd);
        check_eq({tag, " err"}, {31'b0, er}, {31'b0, exp_err});
        check_eq({tag, " we pulses"}, nwe, exp_nwe);
        @(posedge clk);
        #1;
        check_eq({tag, " resp_valid drop"}, {31'b0, resp_valid}, 32'h0);
        check_eq({tag, " ready after"}, {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] wa;
        logic [31:0] wdv;
        int wc;
        int we_before;
        int n_resp;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check_eq("reset req_ready", {31'b0, req_ready}, 32'h1);
        check_eq("reset we", {31'b0, we}, 32'h0);
        check_eq("reset addr", addr, 32'h0);
        check_eq("reset wdata", wdata, 32'h0);
        check_eq("reset resp_valid", {31'b0, resp_valid}, 32'h0);
        check_eq("reset resp_rdata", resp_rdata, 32'h0);
        check_eq("reset resp_err", {31'b0, resp_err}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        preload(8'd1, 32'h808182F3);

        // Loads with sign/zero extension
        run_req("LB 0x4", 1'b0, 3'b000, 32'h4, 32'h0, 3, 32'hFFFFFFF3, 1'b0, 0, wa, wdv, wc);
        run_req("LBU 0x4", 1'b0, 3'b100, 32'h4, 32'h0, 3, 32'h000000F3, 1'b0, 0, wa, wdv, wc);
        run_req("LH 0x6", 1'b0, 3'b001, 32'h6, 32'h0, 3, 32'hFFFF8081, 1'b0, 0, wa, wdv, wc);
        run_req("LHU 0x6", 1'b0, 3'b101, 32'h6, 32'h0, 3, 32'h00008081, 1'b0, 0, wa, wdv, wc);
        run_req("LW 0x4", 1'b0, 3'b010, 32'h4, 32'h0, 3, 32'h808182F3, 1'b0, 0, wa, wdv, wc);

        // Sub-word store via read-modify-write
        run_req("SB 0x5", 1'b1, 3'b000, 32'h5, 32'h123456AB, 4, 32'h0, 1'b0, 1, wa, wdv, wc);
        check_eq("SB 0x5 we addr", wa, 32'h4);
        check_eq("SB 0x5 we data", wdv, 32'h8081ABF3);
        check_eq("SB 0x5 we cycle", wc, 3);
        run_req("LW after SB", 1'b0, 3'b010, 32'h4, 32'h0, 3, 32'h8081ABF3, 1'b0, 0, wa, wdv, wc);

        // Word store skips the read
        run_req("SW 0x8", 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 3, 32'h0, 1'b0, 1, wa, wdv, wc);
        check_eq("SW 0x8 we addr", wa, 32'h8);
        check_eq("SW 0x8 we data", wdv, 32'hDEADBEEF);
        check_eq("SW 0x8 we cycle", wc, 2);
        run_req("LW 0x8", 1'b0, 3'b010, 32'h8, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, wa, wdv, wc);

        // Upper halfword store
        run_req("SH 0xA", 1'b1, 3'b001, 32'hA, 32'h5555CAFE, 4, 32'h0, 1'b0, 1, wa, wdv, wc);
        check_eq("SH 0xA we data", wdv, 32'hCAFEBEEF);
        run_req("LW after SH", 1'b0, 3'b010, 32'h8, 32'h0, 3, 32'hCAFEBEEF, 1'b0, 0, wa, wdv, wc);

        // Error cases: no memory access, addr keeps its last value (0x8)
        run_req("err LW 0x6", 1'b0, 3'b010, 32'h6, 32'h0, 2, 32'h0, 1'b1, 0, wa, wdv, wc);
        run_req("err SH 0x3", 1'b1, 3'b001, 32'h3, 32'hFFFF, 2, 32'h0, 1'b1, 0, wa, wdv, wc);
        run_req("err LW 0x400", 1'b0, 3'b010, 32'h400, 32'h0, 2, 32'h0, 1'b1, 0, wa, wdv, wc);
        run_req("err S f3=100", 1'b1, 3'b100, 32'h0, 32'h1, 2, 32'h0, 1'b1, 0, wa, wdv, wc);
        check_eq("err addr held", addr, 32'h8);
        run_req("LH 0x8", 1'b0, 3'b001, 32'h8, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 0, wa, wdv, wc);

        // Reset during the RD phase of a byte store
        we_before  = we_total;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h4;
        req_wdata  = 32'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("rst-RD busy", {31'b0, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("rst-RD we", {31'b0, we}, 32'h0);
        check_eq("rst-RD addr", addr, 32'h0);
        check_eq("rst-RD wdata", wdata, 32'h0);
        check_eq("rst-RD resp_valid", {31'b0, resp_valid}, 32'h0);
        check_eq("rst-RD resp_rdata", resp_rdata, 32'h0);
        check_eq("rst-RD resp_err", {31'b0, resp_err}, 32'h0);
        check_eq("rst-RD req_ready", {31'b0, req_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst-RD no write", we_total - we_before, 0);
        check_eq("rst-RD mem intact", mem[1], 32'h8081ABF3);
        check_eq("rst-RD ready after", {31'b0, req_ready}, 32'h1);

        // req_valid held through WR and RESP is ignored
        we_before  = we_total;
        n_resp     = 0;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'hC;
        req_wdata  = 32'h11223344;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) n_resp++;
            if (i == 1) req_valid = 1'b0;
        end
        check_eq("held valid responses", n_resp, 1);
        check_eq("held valid writes", we_total - we_before, 1);
        check_eq("held valid mem", mem[3], 32'h11223344);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side master for data_memory. It sits between the RV32 execute stage and the data memory, and turns RV32I load/store requests into word-aligned memory accesses.
- Performs byte/halfword extraction with sign or zero extension for loads.
- Performs read-modify-write for sub-word stores, because data_memory has only a single word-wide write enable.
- Flags misaligned, out-of-range and illegal-width requests without touching memory.

Parameters:
MEM_SIZE, 1024, data memory size in bytes; byte addresses >= MEM_SIZE are access faults.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high at a rising edge.
req_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32 width: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU and HU are loads only).
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.
we  output  1  data_memory write enable.
addr  output  32  data_memory address, always word aligned ({a[31:2],2'b00}).
wdata  output  32  data_memory write data.
rdata  input  32  data_memory read data, combinational from addr.

Behaviour:
- State machine: IDLE, RD, WR, RESP. Request fields are latched at acceptance.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, req_ready = 1.
  - we = 0, addr = 0, wdata = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
- IDLE, on acceptance, checks the request in this priority order:
  - Illegal funct3: 011, 110, 111, or a store with 100/101 -> RESP with err.
  - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0 -> RESP with err.
  - req_addr >= MEM_SIZE -> RESP with err.
  - Otherwise register addr = aligned address, then go to:
    - WR for SW,
    - RD for all loads and for SB/SH.
- RD (exactly one cycle):
  - addr is held; rdata is captured into a word buffer at the closing edge.
  - Load -> RESP.
  - SB/SH -> WR, with the merged word registered into wdata.
- Lane selection:
  - Byte lane = addr[1:0], little-endian.
  - Halfword lane = addr[1].
  - B/H loads sign-extend; BU/HU loads zero-extend; W loads pass through.
- Store merge:
  - SB replaces byte lane addr[1:0] with req_wdata[7:0].
  - SH replaces halfword lane addr[1] with req_wdata[15:0].
  - SW writes req_wdata unchanged.
  - All other bytes keep their RD-captured values.
- WR: we = 1 for exactly one cycle with stable addr and wdata, then RESP. we is 0 in every other state.
- RESP:
  - resp_valid = 1 for one cycle with resp_rdata and resp_err, then IDLE.
  - resp_rdata = 0 when resp_err = 1 or the request was a store.
  - resp_valid returns to 0 afterwards; resp_rdata and resp_err hold their last value.
- Latency, counting the acceptance cycle as cycle 1:
  - Error: resp_valid in cycle 2.
  - Load or SW: resp_valid in cycle 3.
  - SB/SH: resp_valid in cycle 4.
- There is no response backpressure; the consumer must take resp_valid when it pulses.
- req_valid outside IDLE is ignored; the request is not queued. Back-to-back requests are accepted in the cycle after RESP.
- Reset asserted mid-operation aborts immediately:
  - Reset in RD of an SB/SH -> no write ever occurs and memory is unchanged.
  - Reset during WR drops we asynchronously; the write is not guaranteed.
- Error responses generate no memory access: we = 0 and addr is not updated.

Test Plan:
- Preload word 0x4 = 0x808182F3. LB @0x4 -> resp_rdata 0xFFFFFFF3; LBU @0x4 -> 0x000000F3; resp_valid in cycle 3, resp_err 0.
- Same preload. LH @0x6 -> 0xFFFF8081; LHU @0x6 -> 0x00008081; LW @0x4 -> 0x808182F3.
- Same preload. SB wdata 0x123456AB @0x5 -> exactly one we pulse with addr 0x4, wdata 0x8081ABF3; resp_valid in cycle 4; a following LW @0x4 returns 0x8081ABF3.
- SW 0xDEADBEEF @0x8 -> we in cycle 2, with no preceding read state; LW @0x8 -> 0xDEADBEEF.
- Error cases, each giving resp_err = 1, resp_rdata = 0, resp_valid in cycle 2, and we = 0 throughout:
  - LW @0x6,
  - SH @0x3,
  - LW @0x400 (MEM_SIZE = 1024),
  - store with funct3 100.
- Reset robustness:
  - Pull rst_n low during RD of SB 0xFF @0x4 -> we never asserted, word 0x4 unchanged; all outputs at reset values immediately, req_ready = 1 after release.
  - req_valid held high during WR -> ignored, with exactly one response.
